l2_ctrl_regs: RTL and testbench
===============================

Name: l2_ctrl_regs

Overview:
- Parametrised successor to the L2 control-register block.
- Holds the MSHR free counter with simultaneous alloc/free, the stall and conflict flags, fwd-stall entry tracking with automatic end detection, and the ongoing-atomic flag.
- Adds a flush walker FSM that steps through every (set, way) under a valid/advance handshake.
- Sits beside the L2 main control FSM; all outputs are registered.

Parameters:
- N_MSHR, 16, number of MSHR entries.
- MSHR_BITS, $clog2(N_MSHR), MSHR index width.
- N_SETS, 256, L2 sets to walk on flush (power of two).
- SET_BITS, $clog2(N_SETS), set index width.
- N_WAYS, 16, L2 ways per set (power of two).
- WAY_BITS, $clog2(N_WAYS), way index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- mshr_alloc  in  1  allocate one MSHR entry this cycle
- mshr_free  in  1  release one MSHR entry this cycle
- mshr_free_idx  in  MSHR_BITS  index of the entry being released
- set_evict_stall / clr_evict_stall  in  1 each  evict-stall triggers
- set_set_conflict / clr_set_conflict  in  1 each  set-conflict triggers
- set_fwd_stall  in  1  start fwd stall; captures fwd_stall_entry_in
- fwd_stall_entry_in  in  MSHR_BITS  MSHR entry blocking the forward
- clr_fwd_stall  in  1  end fwd stall; clears fwd_stall and fwd_stall_ended
- set_ongoing_atomic / clr_ongoing_atomic  in  1 each  atomic triggers
- flush_start  in  1  begin a full-cache walk
- flush_adv  in  1  consumer accepted the current (set, way)
- mshr_cnt  out  MSHR_BITS+1  free MSHR entries
- mshr_full  out  1  mshr_cnt==0
- mshr_empty  out  1  mshr_cnt==N_MSHR
- mshr_err  out  1  sticky under/overflow flag
- evict_stall, set_conflict, fwd_stall, fwd_stall_ended, ongoing_atomic  out  1 each  flags
- fwd_stall_entry  out  MSHR_BITS  captured blocking entry
- flush_valid  out  1  flush_set/flush_way are valid
- flush_set  out  SET_BITS  current walk set
- flush_way  out  WAY_BITS  current walk way
- flush_done  out  1  one-cycle pulse at end of walk

Behaviour:
- Reset values: mshr_cnt=N_MSHR, mshr_empty=1; every other output 0. Reset asserted mid-flush aborts the walk to IDLE with no flush_done.
- mshr_cnt:
  - alloc only: -1. free only: +1. Both: unchanged.
  - alloc-only at cnt 0: ignored, mshr_err<=1.
  - free-only at cnt N_MSHR: ignored, mshr_err<=1.
  - mshr_err clears only on reset.
  - mshr_full and mshr_empty are decoded from the registered count.
- evict_stall, set_conflict, ongoing_atomic: clear has priority over set; otherwise hold; value visible the cycle after the trigger.
- fwd_stall:
  - Priority clr > set. On set, fwd_stall_entry<=fwd_stall_entry_in and fwd_stall_ended<=0.
  - fwd_stall_entry holds until the next set_fwd_stall.
- fwd_stall_ended:
  - Sets to 1 when fwd_stall==1 && mshr_free && mshr_free_idx==fwd_stall_entry. A concurrent mshr_alloc does not block this.
  - Cleared by clr_fwd_stall or set_fwd_stall.
  - Same-cycle set_fwd_stall plus matching free: stall set, ended=0; the free is compared against the old entry.
- Flush FSM states IDLE, WALK, DONE:
  - IDLE: flush_start -> WALK with set=0, way=0, flush_valid=1.
  - WALK: flush_adv with way<N_WAYS-1 -> way+1.
  - WALK: flush_adv with way==N_WAYS-1 -> way=0, set+1.
  - WALK: flush_adv at set==N_SETS-1 and way==N_WAYS-1 -> DONE, flush_valid=0.
  - WALK: no flush_adv -> hold set and way.
  - DONE: flush_done=1 for exactly one cycle -> IDLE; set and way return to 0.
  - flush_start in WALK or DONE is ignored. flush_adv in IDLE or DONE is ignored.
  - Latency: flush_valid rises the cycle after flush_start. A full walk with flush_adv held high takes N_SETS*N_WAYS cycles plus 1 DONE cycle.

Decomposition:
- l2_pkg (shared): flush_state_t enum {IDLE, WALK, DONE}, and the default constants N_MSHR, N_SETS, N_WAYS.
- Sub-module l2_flush_walker: the FSM plus set/way counters.
- Remaining flag and counter logic is flat in l2_ctrl_regs.

Test Plan:
- Reset then 16 mshr_alloc -> mshr_cnt 16→0, mshr_full=1. A 17th alloc -> cnt stays 0, mshr_err=1.
- cnt=5 with alloc and free in the same cycle -> cnt=5. Free at cnt=16 -> cnt stays 16, mshr_err=1.
- set_fwd_stall with entry_in=3, then free idx 2 -> ended=0. Then free idx 3 -> ended=1 next cycle. Then clr_fwd_stall -> fwd_stall=0, ended=0.
- set_evict_stall and clr_evict_stall in the same cycle -> evict_stall=0. Repeat the clr-over-set check for set_conflict and ongoing_atomic.
- N_SETS=4, N_WAYS=2: flush_start, flush_adv held high -> (0,0),(0,1),(1,0)…(3,1) over 8 cycles, then flush_done pulses once, flush_valid=0. flush_start mid-walk is ignored.
- Drop flush_adv for 3 cycles at (2,1) -> position held. Assert rst at (2,1) -> IDLE, set=way=0, no flush_done.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and default sizing for the L2 control-register slice.
// Flush walker state encoding lives here so the top and the walker agree.
package l2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } flush_state_t;

  localparam int DEF_N_MSHR = 16;
  localparam int DEF_N_SETS = 256;
  localparam int DEF_N_WAYS = 16;

endpackage

// File: rtl/l2_flush_walker.sv
// Flush walker: steps (set, way) from (0,0) upward, way fastest; position valid the cycle after flush_start.
// Holds position while flush_adv is low; flush_done pulses for one cycle after the last (set, way) is accepted.
module l2_flush_walker
  import l2_pkg::*;
#(
  parameter int N_SETS   = DEF_N_SETS,
  parameter int N_WAYS   = DEF_N_WAYS,
  parameter int SET_BITS = $clog2(N_SETS),
  parameter int WAY_BITS = $clog2(N_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_start,
  input  logic                flush_adv,
  output logic                flush_valid,
  output logic [SET_BITS-1:0] flush_set,
  output logic [WAY_BITS-1:0] flush_way,
  output logic                flush_done
);

  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(N_SETS - 1);
  localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(N_WAYS - 1);

  flush_state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      flush_valid <= 1'b0;
      flush_set   <= '0;
      flush_way   <= '0;
      flush_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_start) begin
            state       <= WALK;
            flush_valid <= 1'b1;
            flush_set   <= '0;
            flush_way   <= '0;
          end
        end
        WALK: begin
          if (flush_adv) begin
            if (flush_way == LAST_WAY) begin
              flush_way <= '0;
              if (flush_set == LAST_SET) begin
                // Last position accepted: drop valid and announce completion.
                flush_set   <= '0;
                state       <= DONE;
                flush_valid <= 1'b0;
                flush_done  <= 1'b1;
              end else begin
                flush_set <= flush_set + SET_BITS'(1);
              end
            end else begin
              flush_way <= flush_way + WAY_BITS'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          flush_done <= 1'b0;
          flush_set  <= '0;
          flush_way  <= '0;
        end
        default: begin
          state       <= IDLE;
          flush_valid <= 1'b0;
          flush_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/l2_ctrl_regs.sv
// L2 control registers: MSHR free counter, stall/conflict/atomic flags, fwd-stall tracking, flush walker.
// All outputs registered, one-cycle update latency; no backpressure except the flush walker's flush_adv.
module l2_ctrl_regs
  import l2_pkg::*;
#(
  parameter int N_MSHR    = DEF_N_MSHR,
  parameter int MSHR_BITS = $clog2(N_MSHR),
  parameter int N_SETS    = DEF_N_SETS,
  parameter int SET_BITS  = $clog2(N_SETS),
  parameter int N_WAYS    = DEF_N_WAYS,
  parameter int WAY_BITS  = $clog2(N_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mshr_alloc,
  input  logic                 mshr_free,
  input  logic [MSHR_BITS-1:0] mshr_free_idx,
  input  logic                 set_evict_stall,
  input  logic                 clr_evict_stall,
  input  logic                 set_set_conflict,
  input  logic                 clr_set_conflict,
  input  logic                 set_fwd_stall,
  input  logic [MSHR_BITS-1:0] fwd_stall_entry_in,
  input  logic                 clr_fwd_stall,
  input  logic                 set_ongoing_atomic,
  input  logic                 clr_ongoing_atomic,
  input  logic                 flush_start,
  input  logic                 flush_adv,
  output logic [MSHR_BITS:0]   mshr_cnt,
  output logic                 mshr_full,
  output logic                 mshr_empty,
  output logic                 mshr_err,
  output logic                 evict_stall,
  output logic                 set_conflict,
  output logic                 fwd_stall,
  output logic                 fwd_stall_ended,
  output logic                 ongoing_atomic,
  output logic [MSHR_BITS-1:0] fwd_stall_entry,
  output logic                 flush_valid,
  output logic [SET_BITS-1:0]  flush_set,
  output logic [WAY_BITS-1:0]  flush_way,
  output logic                 flush_done
);

  localparam logic [MSHR_BITS:0] CNT_MAX = (MSHR_BITS + 1)'(N_MSHR);

  logic [MSHR_BITS:0] cnt_nxt;
  logic               err_nxt;
  logic               fwd_hit;

  // Simultaneous alloc+free cancel out; out-of-range moves are dropped and flagged.
  always_comb begin
    cnt_nxt = mshr_cnt;
    err_nxt = mshr_err;
    if (mshr_alloc && !mshr_free) begin
      if (mshr_cnt == '0) err_nxt = 1'b1;
      else                cnt_nxt = mshr_cnt - 1'b1;
    end else if (mshr_free && !mshr_alloc) begin
      if (mshr_cnt == CNT_MAX) err_nxt = 1'b1;
      else                     cnt_nxt = mshr_cnt + 1'b1;
    end
  end

  // Compared against the currently captured entry, not one being loaded this cycle.
  assign fwd_hit = fwd_stall && mshr_free && (mshr_free_idx == fwd_stall_entry);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mshr_cnt        <= CNT_MAX;
      mshr_full       <= 1'b0;
      mshr_empty      <= 1'b1;
      mshr_err        <= 1'b0;
      evict_stall     <= 1'b0;
      set_conflict    <= 1'b0;
      ongoing_atomic  <= 1'b0;
      fwd_stall       <= 1'b0;
      fwd_stall_ended <= 1'b0;
      fwd_stall_entry <= '0;
    end else begin
      mshr_cnt   <= cnt_nxt;
      mshr_full  <= (cnt_nxt == '0);
      mshr_empty <= (cnt_nxt == CNT_MAX);
      mshr_err   <= err_nxt;

      if (clr_evict_stall)      evict_stall <= 1'b0;
      else if (set_evict_stall) evict_stall <= 1'b1;

      if (clr_set_conflict)      set_conflict <= 1'b0;
      else if (set_set_conflict) set_conflict <= 1'b1;

      if (clr_ongoing_atomic)      ongoing_atomic <= 1'b0;
      else if (set_ongoing_atomic) ongoing_atomic <= 1'b1;

      if (clr_fwd_stall) begin
        fwd_stall       <= 1'b0;
        fwd_stall_ended <= 1'b0;
      end else if (set_fwd_stall) begin
        fwd_stall       <= 1'b1;
        fwd_stall_entry <= fwd_stall_entry_in;
        fwd_stall_ended <= 1'b0;
      end else if (fwd_hit) begin
        fwd_stall_ended <= 1'b1;
      end
    end
  end

  l2_flush_walker #(
    .N_SETS  (N_SETS),
    .N_WAYS  (N_WAYS),
    .SET_BITS(SET_BITS),
    .WAY_BITS(WAY_BITS)
  ) u_flush_walker (
    .clk        (clk),
    .rst        (rst),
    .flush_start(flush_start),
    .flush_adv  (flush_adv),
    .flush_valid(flush_valid),
    .flush_set  (flush_set),
    .flush_way  (flush_way),
    .flush_done (flush_done)
  );

endmodule

// File: tb/tb_l2_ctrl_regs.sv
// Directed bench for l2_ctrl_regs with a small 4x2 flush geometry and 16 MSHRs.
module tb_l2_ctrl_regs;

  localparam int N_MSHR    = 16;
  localparam int MSHR_BITS = 4;
  localparam int N_SETS    = 4;
  localparam int SET_BITS  = 2;
  localparam int N_WAYS    = 2;
  localparam int WAY_BITS  = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mshr_alloc, mshr_free;
  logic [MSHR_BITS-1:0] mshr_free_idx;
  logic                 set_evict_stall, clr_evict_stall;
  logic                 set_set_conflict, clr_set_conflict;
  logic                 set_fwd_stall, clr_fwd_stall;
  logic [MSHR_BITS-1:0] fwd_stall_entry_in;
  logic                 set_ongoing_atomic, clr_ongoing_atomic;
  logic                 flush_start, flush_adv;
  logic [MSHR_BITS:0]   mshr_cnt;
  logic                 mshr_full, mshr_empty, mshr_err;
  logic                 evict_stall, set_conflict, fwd_stall, fwd_stall_ended, ongoing_atomic;
  logic [MSHR_BITS-1:0] fwd_stall_entry;
  logic                 flush_valid;
  logic [SET_BITS-1:0]  flush_set;
  logic [WAY_BITS-1:0]  flush_way;
  logic                 flush_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_ctrl_regs #(
    .N_MSHR(N_MSHR), .MSHR_BITS(MSHR_BITS),
    .N_SETS(N_SETS), .SET_BITS(SET_BITS),
    .N_WAYS(N_WAYS), .WAY_BITS(WAY_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .mshr_alloc(mshr_alloc), .mshr_free(mshr_free), .mshr_free_idx(mshr_free_idx),
    .set_evict_stall(set_evict_stall), .clr_evict_stall(clr_evict_stall),
    .set_set_conflict(set_set_conflict), .clr_set_conflict(clr_set_conflict),
    .set_fwd_stall(set_fwd_stall), .fwd_stall_entry_in(fwd_stall_entry_in),
    .clr_fwd_stall(clr_fwd_stall),
    .set_ongoing_atomic(set_ongoing_atomic), .clr_ongoing_atomic(clr_ongoing_atomic),
    .flush_start(flush_start), .flush_adv(flush_adv),
    .mshr_cnt(mshr_cnt), .mshr_full(mshr_full), .mshr_empty(mshr_empty), .mshr_err(mshr_err),
    .evict_stall(evict_stall), .set_conflict(set_conflict), .fwd_stall(fwd_stall),
    .fwd_stall_ended(fwd_stall_ended), .ongoing_atomic(ongoing_atomic),
    .fwd_stall_entry(fwd_stall_entry),
    .flush_valid(flush_valid), .flush_set(flush_set), .flush_way(flush_way),
    .flush_done(flush_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    mshr_alloc = 0; mshr_free = 0; mshr_free_idx = '0;
    set_evict_stall = 0; clr_evict_stall = 0;
    set_set_conflict = 0; clr_set_conflict = 0;
    set_fwd_stall = 0; clr_fwd_stall = 0; fwd_stall_entry_in = '0;
    set_ongoing_atomic = 0; clr_ongoing_atomic = 0;
    flush_start = 0; flush_adv = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(mshr_cnt), 32'd16);
    chk("rst_empty", 32'(mshr_empty), 32'd1);
    chk("rst_full", 32'(mshr_full), 32'd0);
    chk("rst_err", 32'(mshr_err), 32'd0);
    chk("rst_flags", 32'({evict_stall, set_conflict, fwd_stall, fwd_stall_ended, ongoing_atomic}), 32'd0);
    chk("rst_entry", 32'(fwd_stall_entry), 32'd0);
    chk("rst_flush", 32'({flush_valid, flush_set, flush_way, flush_done}), 32'd0);
    rst = 1'b1;
    tick();

    // Free with every entry already free
    mshr_free = 1; tick(); mshr_free = 0;
    chk("free_at_max_cnt", 32'(mshr_cnt), 32'd16);
    chk("free_at_max_err", 32'(mshr_err), 32'd1);
    chk("free_at_max_empty", 32'(mshr_empty), 32'd1);
    tick();
    chk("err_sticky", 32'(mshr_err), 32'd1);

    rst = 1'b0; #2;
    chk("async_rst_err", 32'(mshr_err), 32'd0);
    rst = 1'b1;
    tick();

    // Drain all 16 entries
    mshr_alloc = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("alloc_cnt", 32'(mshr_cnt), 32'(15 - i));
    end
    chk("alloc_full", 32'(mshr_full), 32'd1);
    chk("alloc_empty", 32'(mshr_empty), 32'd0);
    chk("alloc_no_err", 32'(mshr_err), 32'd0);
    tick();
    mshr_alloc = 0;
    chk("alloc17_cnt", 32'(mshr_cnt), 32'd0);
    chk("alloc17_err", 32'(mshr_err), 32'd1);
    chk("alloc17_full", 32'(mshr_full), 32'd1);

    mshr_free = 1; mshr_free_idx = 4'd0;
    repeat (5) tick();
    mshr_free = 0;
    chk("free5_cnt", 32'(mshr_cnt), 32'd5);
    chk("free5_full", 32'(mshr_full), 32'd0);
    mshr_alloc = 1; mshr_free = 1; tick();
    mshr_alloc = 0; mshr_free = 0;
    chk("alloc_free_cnt", 32'(mshr_cnt), 32'd5);

    // Forward-stall tracking, cnt 5 -> 9
    set_fwd_stall = 1; fwd_stall_entry_in = 4'd3; tick(); set_fwd_stall = 0;
    chk("fwd_set", 32'(fwd_stall), 32'd1);
    chk("fwd_entry3", 32'(fwd_stall_entry), 32'd3);
    chk("fwd_ended_init", 32'(fwd_stall_ended), 32'd0);
    mshr_free = 1; mshr_free_idx = 4'd2; tick();
    chk("fwd_free2", 32'(fwd_stall_ended), 32'd0);
    mshr_free_idx = 4'd3; tick(); mshr_free = 0;
    chk("fwd_free3", 32'(fwd_stall_ended), 32'd1);
    tick();
    chk("fwd_ended_hold", 32'(fwd_stall_ended), 32'd1);
    clr_fwd_stall = 1; tick(); clr_fwd_stall = 0;
    chk("fwd_clr_stall", 32'(fwd_stall), 32'd0);
    chk("fwd_clr_ended", 32'(fwd_stall_ended), 32'd0);
    chk("fwd_entry_hold", 32'(fwd_stall_entry), 32'd3);

    set_fwd_stall = 1; fwd_stall_entry_in = 4'd3; tick();
    fwd_stall_entry_in = 4'd7; mshr_free = 1; mshr_free_idx = 4'd3; tick();
    set_fwd_stall = 0;
    chk("fwd_reset_stall", 32'(fwd_stall), 32'd1);
    chk("fwd_reset_ended", 32'(fwd_stall_ended), 32'd0);
    chk("fwd_entry7", 32'(fwd_stall_entry), 32'd7);
    tick();
    chk("fwd_old_idx", 32'(fwd_stall_ended), 32'd0);
    mshr_alloc = 1; mshr_free_idx = 4'd7; tick();
    mshr_alloc = 0; mshr_free = 0;
    chk("fwd_alloc_hit", 32'(fwd_stall_ended), 32'd1);
    chk("fwd_cnt", 32'(mshr_cnt), 32'd9);
    clr_fwd_stall = 1; set_fwd_stall = 1; fwd_stall_entry_in = 4'd1; tick();
    clr_fwd_stall = 0; set_fwd_stall = 0;
    chk("fwd_clr_prio", 32'({fwd_stall, fwd_stall_ended}), 32'd0);

    // Flag set/hold/clear-priority
    set_evict_stall = 1; set_set_conflict = 1; set_ongoing_atomic = 1; tick();
    set_evict_stall = 0; set_set_conflict = 0; set_ongoing_atomic = 0;
    chk("flags_set", 32'({evict_stall, set_conflict, ongoing_atomic}), 32'b111);
    tick();
    chk("flags_hold", 32'({evict_stall, set_conflict, ongoing_atomic}), 32'b111);
    set_evict_stall = 1; clr_evict_stall = 1; tick();
    set_evict_stall = 0; clr_evict_stall = 0;
    chk("evict_clr_prio", 32'({evict_stall, set_conflict, ongoing_atomic}), 32'b011);
    set_set_conflict = 1; clr_set_conflict = 1; tick();
    set_set_conflict = 0; clr_set_conflict = 0;
    chk("conflict_clr_prio", 32'({evict_stall, set_conflict, ongoing_atomic}), 32'b001);
    set_ongoing_atomic = 1; clr_ongoing_atomic = 1; tick();
    set_ongoing_atomic = 0; clr_ongoing_atomic = 0;
    chk("atomic_clr_prio", 32'({evict_stall, set_conflict, ongoing_atomic}), 32'b000);

    // flush_adv in IDLE does nothing
    flush_adv = 1; tick(); flush_adv = 0;
    chk("idle_adv", 32'({flush_valid, flush_set, flush_way, flush_done}), 32'd0);

    // Full walk with flush_adv held
    flush_start = 1; tick(); flush_start = 0;
    chk("walk_pos0", 32'({flush_valid, flush_set, flush_way}), 32'b1_00_0);
    flush_adv = 1;
    for (int k = 1; k < 8; k++) begin
      flush_start = (k == 3);
      tick();
      chk("walk_pos", 32'({flush_valid, flush_set, flush_way}), 32'({1'b1, 3'(k)}));
      chk("walk_no_done", 32'(flush_done), 32'd0);
    end
    flush_start = 0;
    tick();
    chk("walk_done", 32'(flush_done), 32'd1);
    chk("walk_done_valid", 32'({flush_valid, flush_set, flush_way}), 32'd0);
    tick();
    flush_adv = 0;
    chk("walk_done_pulse", 32'(flush_done), 32'd0);
    chk("walk_idle_valid", 32'(flush_valid), 32'd0);

    // Stall at (2,1), then reset mid-walk
    flush_start = 1; tick(); flush_start = 0;
    flush_adv = 1;
    repeat (5) tick();
    flush_adv = 0;
    chk("stall_pos", 32'({flush_valid, flush_set, flush_way}), 32'b1_10_1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", 32'({flush_valid, flush_set, flush_way}), 32'b1_10_1);
    end
    flush_adv = 1;
    rst = 1'b0; #2;
    chk("abort_rst", 32'({flush_valid, flush_set, flush_way, flush_done}), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_idle", 32'({flush_valid, flush_set, flush_way, flush_done}), 32'd0);
    tick();
    flush_adv = 0;
    chk("abort_no_done", 32'({flush_valid, flush_done}), 32'd0);
    chk("abort_cnt", 32'(mshr_cnt), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
